// File: rtl/inst_fetch.sv
// Instruction fetch stage: one-word-per-line direct-mapped I-cache in front of a RAM fetch port.
// Define ICACHE_EN to build the cache; without it every lookup misses and goes to RAM.
module inst_fetch #(
  parameter int          ICACHE_IDX_W = 6,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_error,
  input  logic [31:0] branch_target,
  output logic        inst_read,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  input  logic        inst_done,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [1:0]  state_dbg
);

  // Handshake: the decode slot (if_valid/if_pc/if_inst) is free when !if_valid || !stall;
  // if_valid && !stall at a rising edge means decode took the instruction.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] hold_q, hold_n;
  logic [31:0] inst_addr_n, if_pc_n, if_inst_n;
  logic        inst_read_n, if_valid_n;
  logic        slot_free;
  logic        hit;
  logic [31:0] hit_data;

  assign slot_free = !if_valid || !stall;
  assign state_dbg = state;

`ifdef ICACHE_EN
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 16 - ICACHE_IDX_W;

  logic [31:0]             line_data [LINES];
  logic [TAG_W-1:0]        line_tag  [LINES];
  logic [LINES-1:0]        line_valid;
  logic [ICACHE_IDX_W-1:0] idx;
  logic [TAG_W-1:0]        tag;
  logic                    cache_we;

  // pc is frozen while a miss is outstanding, so idx/tag also address the fill.
  assign idx      = pc[ICACHE_IDX_W+1:2];
  assign tag      = pc[17:ICACHE_IDX_W+2];
  assign hit      = line_valid[idx] && (line_tag[idx] == tag);
  assign hit_data = line_data[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid <= '0;
    end else if (cache_we) begin
      line_valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cache_we) begin
      line_data[idx] <= inst_data;
      line_tag[idx]  <= tag;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    hold_n      = hold_q;
    inst_read_n = inst_read;
    inst_addr_n = inst_addr;
    if_valid_n  = if_valid && stall;
    if_pc_n     = if_pc;
    if_inst_n   = if_inst;
`ifdef ICACHE_EN
    cache_we    = 1'b0;
`endif
    if (branch_error) begin
      // Flush wins over any reply arriving in the same cycle; the target is looked up next cycle.
      state_n     = IDLE;
      pc_n        = branch_target & 32'hFFFF_FFFC;
      hold_n      = '0;
      inst_read_n = 1'b0;
      if_valid_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            inst_read_n = 1'b1;
            inst_addr_n = pc;
            state_n     = FETCH;
          end else if (slot_free) begin
            if_valid_n = 1'b1;
            if_pc_n    = pc;
            if_inst_n  = hit_data;
            pc_n       = pc + 32'd4;
          end
        end
        FETCH: begin
          if (inst_done) begin
            inst_read_n = 1'b0;
`ifdef ICACHE_EN
            cache_we    = 1'b1;
`endif
            if (slot_free) begin
              if_valid_n = 1'b1;
              if_pc_n    = pc;
              if_inst_n  = inst_data;
              pc_n       = pc + 32'd4;
              state_n    = IDLE;
            end else begin
              hold_n  = inst_data;
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            if_valid_n = 1'b1;
            if_pc_n    = pc;
            if_inst_n  = hold_q;
            pc_n       = pc + 32'd4;
            state_n    = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      hold_q    <= '0;
      inst_read <= 1'b0;
      inst_addr <= '0;
      if_valid  <= 1'b0;
      if_pc     <= '0;
      if_inst   <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      hold_q    <= hold_n;
      inst_read <= inst_read_n;
      inst_addr <= inst_addr_n;
      if_valid  <= if_valid_n;
      if_pc     <= if_pc_n;
      if_inst   <= if_inst_n;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch; expectations adapt to the ICACHE_EN build option.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_error;
  logic [31:0] branch_target;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_done;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [1:0]  state_dbg;

  int passed = 0;
  int total  = 0;
  logic [31:0] prog [4];

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_error (branch_error),
    .branch_target(branch_target),
    .inst_read    (inst_read),
    .inst_addr    (inst_addr),
    .inst_data    (inst_data),
    .inst_done    (inst_done),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .state_dbg    (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Waits (bounded) for a fetch request and checks its address.
  task automatic wait_req(input logic [31:0] addr);
    int n = 0;
    while (inst_read !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(inst_read), 32'd1);
    chk("req_addr", inst_addr, addr);
  endtask

  // RAM reply two cycles after the request; with stall=0 the word is delivered on the reply edge.
  task automatic serve(input logic [31:0] addr, input logic [31:0] data);
    wait_req(addr);
    @(negedge clk);
    chk("req_held", 32'(inst_read), 32'd1);
    chk("addr_stable", inst_addr, addr);
    inst_done = 1'b1;
    inst_data = data;
    @(negedge clk);
    inst_done = 1'b0;
    inst_data = '0;
    chk("dlv_valid", 32'(if_valid), 32'd1);
    chk("dlv_pc", if_pc, addr);
    chk("dlv_inst", if_inst, data);
    chk("read_low_after_done", 32'(inst_read), 32'd0);
  endtask

  initial begin
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_0113;
    prog[3] = 32'h0000_006F;

    rst = 1'b1; stall = 1'b0; branch_error = 1'b0; branch_target = '0;
    inst_data = '0; inst_done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_read", 32'(inst_read), 32'd0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_state", 32'(state_dbg), 32'd0);

    // First fetch: request one cycle after release, word delivered on the reply edge
    rst = 1'b0;
    @(negedge clk);
    chk("first_read", 32'(inst_read), 32'd1);
    chk("first_addr", inst_addr, 32'h0);
    chk("first_state", 32'(state_dbg), 32'd1);
    serve(32'h0, prog[0]);

    // Stall for three edges while the reply for 0x4 arrives
    stall = 1'b1;
    @(negedge clk);
    chk("stall_req", 32'(inst_read), 32'd1);
    chk("stall_addr", inst_addr, 32'h4);
    chk("stall_keep_valid", 32'(if_valid), 32'd1);
    chk("stall_keep_pc0", if_pc, 32'h0);
    inst_done = 1'b1;
    inst_data = prog[1];
    @(negedge clk);
    inst_done = 1'b0;
    inst_data = '0;
    chk("hold_state", 32'(state_dbg), 32'd2);
    chk("hold_read_low", 32'(inst_read), 32'd0);
    chk("hold_pc", if_pc, 32'h0);
    chk("hold_inst", if_inst, prog[0]);
    @(negedge clk);
    chk("hold_state2", 32'(state_dbg), 32'd2);
    chk("hold_pc2", if_pc, 32'h0);
    chk("hold_inst2", if_inst, prog[0]);
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_valid", 32'(if_valid), 32'd1);
    chk("unstall_pc", if_pc, 32'h4);
    chk("unstall_inst", if_inst, prog[1]);
    chk("unstall_state", 32'(state_dbg), 32'd0);

    serve(32'h8, prog[2]);
    serve(32'hC, prog[3]);

    // Branch back to 0; low target bits must be dropped
    branch_error = 1'b1;
    branch_target = 32'h3;
    @(negedge clk);
    branch_error = 1'b0;
    chk("flush_valid", 32'(if_valid), 32'd0);
    chk("flush_read", 32'(inst_read), 32'd0);

`ifdef ICACHE_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("loop_hit_no_read", 32'(inst_read), 32'd0);
      chk("loop_hit_valid", 32'(if_valid), 32'd1);
      chk("loop_hit_pc", if_pc, 32'(i * 4));
      chk("loop_hit_inst", if_inst, prog[i]);
    end
`else
    for (int i = 0; i < 4; i++) begin
      serve(32'(i * 4), prog[i]);
    end
`endif

    // Reply coinciding with a flush to 0x104 is dropped
    wait_req(32'h10);
    inst_done = 1'b1;
    inst_data = 32'hDEAD_BEEF;
    branch_error = 1'b1;
    branch_target = 32'h104;
    @(negedge clk);
    inst_done = 1'b0;
    inst_data = '0;
    branch_error = 1'b0;
    chk("br_done_valid", 32'(if_valid), 32'd0);
    chk("br_done_read", 32'(inst_read), 32'd0);
    chk("br_done_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    chk("br_next_read", 32'(inst_read), 32'd1);
    chk("br_next_addr", inst_addr, 32'h104);
    serve(32'h104, 32'h0040_0213);

    // Jump to 0x10: must miss because the dropped reply never filled the line
    branch_error = 1'b1;
    branch_target = 32'h10;
    @(negedge clk);
    branch_error = 1'b0;
    chk("rejump_valid", 32'(if_valid), 32'd0);
    @(negedge clk);
    chk("nofill_read", 32'(inst_read), 32'd1);
    chk("nofill_addr", inst_addr, 32'h10);
    chk("nofill_valid", 32'(if_valid), 32'd0);

    // Reset mid-fetch, stale replies ignored, refetch at RESET_PC
    rst = 1'b1;
    @(negedge clk);
    inst_done = 1'b1;
    inst_data = 32'h0BAD_0001;
    @(negedge clk);
    inst_done = 1'b0;
    chk("midrst_valid", 32'(if_valid), 32'd0);
    chk("midrst_pc", if_pc, 32'h0);
    chk("midrst_inst", if_inst, 32'h0);
    chk("midrst_read", 32'(inst_read), 32'd0);
    chk("midrst_addr", inst_addr, 32'h0);
    rst = 1'b0;
    inst_done = 1'b1;
    inst_data = 32'h0BAD_0002;
    @(negedge clk);
    inst_done = 1'b0;
    inst_data = '0;
    chk("post_rst_valid", 32'(if_valid), 32'd0);
    chk("post_rst_inst", if_inst, 32'h0);
    chk("post_rst_read", 32'(inst_read), 32'd1);
    chk("post_rst_addr", inst_addr, 32'h0);
    serve(32'h0, prog[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL provide parameter ICACHE_IDX_W, default 6, giving log2 of the number of I-cache lines (64 lines of one 32-bit word each).
REQ-002 SHALL provide parameter RESET_PC, default 32'h0, giving the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1 bit: the downstream decode stage cannot accept an instruction this cycle.
REQ-006 SHALL have ports branch_error (input, 1 bit) and branch_target (input, 32 bits): a misprediction flush and the redirect PC.
REQ-007 SHALL have ports inst_read (output, 1) and inst_addr (output, 32): the fetch request to the RAM controller.
REQ-008 SHALL have ports inst_data (input, 32) and inst_done (input, 1): the RAM controller's fetch reply, valid for one cycle.
REQ-009 SHALL have ports if_valid (output, 1), if_pc (output, 32) and if_inst (output, 32): the registered instruction handed to decode.

Function
REQ-010 SHALL hold an internal 32-bit pc; the lookup index is pc[ICACHE_IDX_W+1:2]; the tag is pc[17:ICACHE_IDX_W+2]; each line has a valid bit.
REQ-011 SHALL define the output slot as free when (!if_valid || !stall); when if_valid && !stall at an edge, the instruction is consumed.
REQ-012 SHALL implement FSM states IDLE, FETCH and HOLD.
REQ-013 IDLE, slot free, cache hit: SHALL load the cached word into if_inst, pc into if_pc, set if_valid, set pc <= pc+4, and stay in IDLE (hit latency 1 cycle, 1 instruction per cycle).
REQ-014 IDLE, cache miss: SHALL register inst_read=1 and inst_addr=pc on the next edge, then enter FETCH.
REQ-015 IDLE, slot not free: SHALL hold pc and all outputs.
REQ-016 FETCH: SHALL keep inst_read=1 and inst_addr stable until inst_done is sampled high.
REQ-017 FETCH with inst_done: SHALL deassert inst_read and write inst_data, tag and valid into the line.
    - slot free: SHALL also drive if_inst/if_pc/if_valid, set pc+4 and go to IDLE.
    - slot not free: SHALL latch inst_data into a hold register and go to HOLD.
REQ-018 HOLD: SHALL deliver the hold register when the slot is free, advance pc by 4 and return to IDLE.
REQ-019 If the slot stays busy with no new instruction delivered, if_valid SHALL clear on the consume edge.
REQ-020 branch_error high at an edge SHALL take priority over everything in every state: pc <= branch_target, if_valid <= 0, inst_read <= 0, hold register discarded, state <= IDLE.
REQ-021 An inst_done that coincides with branch_error SHALL be ignored and SHALL NOT write the cache.
REQ-022 A fetch SHALL NOT be issued in the same cycle as a flush; the first lookup at the target SHALL occur the following cycle.
REQ-023 pc SHALL wrap modulo 2^32 on +4; bits [1:0] of branch_target SHALL be forced to 0.
REQ-024 SHALL keep at most one outstanding request, and inst_read SHALL NOT rise again in the cycle after inst_done.

Reset
REQ-025 rst SHALL set pc=RESET_PC, state=IDLE, inst_read=0, inst_addr=0, if_valid=0, if_pc=0, if_inst=0, and clear every cache valid bit.
REQ-026 rst during FETCH SHALL abandon the request; a later inst_done SHALL be ignored until a new request is issued.
REQ-027 rst SHALL take priority over branch_error.

Configuration
REQ-028 With ICACHE_EN defined, the cache SHALL operate as specified.
REQ-029 Without ICACHE_EN, no cache storage SHALL exist, every lookup SHALL count as a miss (REQ-014 path), and REQ-021 reduces to discarding the coinciding inst_done.

Verification
REQ-030 Reset, stall=0, RAM replies 32'h00000013 two cycles after each request -> inst_read rises one cycle after reset release with inst_addr=0; if_valid=1, if_pc=0, if_inst=32'h00000013 the cycle after inst_done.
REQ-031 Loop over 0x0..0xC fetched twice with ICACHE_EN -> second pass produces no inst_read and if_pc increments by 4 each cycle.
REQ-032 stall=1 held for 3 cycles while inst_done arrives -> state HOLD; if_pc/if_inst unchanged; the new word appears the cycle stall drops.
REQ-033 branch_error with branch_target=32'h104 in the same cycle as inst_done -> if_valid=0, no cache write, next inst_addr=32'h104.
REQ-034 rst asserted mid-FETCH, then inst_done pulsed -> outputs stay 0, and the next request is issued at RESET_PC.
REQ-035 Without ICACHE_EN, the REQ-031 loop -> every instruction issues inst_read, and the data and PC sequence matches the cached run.
